// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank write arbiter.
package regbank_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_NREGS = 8;

  function automatic logic other_sel(input logic sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/register.sv
// Parameterised clock-enable-gated storage register (no reset; contents cleared by the owner).
module register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: the pointer names who wins a tie and moves to the loser after a grant.
module rr_arbiter2
  import regbank_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b,
  output logic o_sel
);

  logic r_ptr;
  logic w_ptr_d;

  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    o_sel   = SEL_A;
    w_ptr_d = r_ptr;
    if (i_en) begin
      if (i_req_a && i_req_b) begin
        o_sel = r_ptr;
      end else if (i_req_b) begin
        o_sel = SEL_B;
      end else begin
        o_sel = SEL_A;
      end
      if (i_req_a || i_req_b) begin
        o_gnt_a = (o_sel == SEL_A);
        o_gnt_b = (o_sel == SEL_B);
        w_ptr_d = other_sel(o_sel);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= SEL_A;
    end else begin
      r_ptr <= w_ptr_d;
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Register bank with a shared round-robin write port, post-reset clear walk and two read ports.
// Define REGBANK_WRITE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned NREGS  = DEFAULT_NREGS,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_A,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [WIDTH-1:0]  DATA_A,
  output logic              ACK_A,
  input  logic              REQ_B,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [WIDTH-1:0]  DATA_B,
  output logic              ACK_B,
  output logic              READY,
  input  logic [ADDR_W-1:0] RD_ADDR0,
  input  logic [ADDR_W-1:0] RD_ADDR1,
  output logic [WIDTH-1:0]  RD_DATA0,
  output logic [WIDTH-1:0]  RD_DATA1
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < NREGS;
  endfunction

  state_e            r_state;
  state_e            w_state_d;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_d;

  logic              w_arb_en;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_sel;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;
  logic [NREGS-1:0]  w_ce;
  logic [WIDTH-1:0]  w_q [NREGS];

  // Reset in the current cycle kills any grant before it reaches ACK or CE.
  assign w_arb_en = (r_state == ARB) && !RST;

  rr_arbiter2 u_arb (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_en    (w_arb_en),
    .i_req_a (REQ_A),
    .i_req_b (REQ_B),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b),
    .o_sel   (w_sel)
  );

  assign ACK_A = w_gnt_a;
  assign ACK_B = w_gnt_b;
  assign READY = (r_state == ARB) && !RST;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (r_state == CLEAR) begin
      if (r_cnt == LAST_IDX) begin
        w_state_d = ARB;
        w_cnt_d   = '0;
      end else begin
        w_cnt_d = r_cnt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Out-of-range grants are still acked but leave w_we low, so nothing is written.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!RST) begin
      case (r_state)
        CLEAR: begin
          w_we    = 1'b1;
          w_waddr = r_cnt;
        end
        ARB: begin
          if (w_gnt_a || w_gnt_b) begin
            w_waddr = (w_sel == SEL_B) ? ADDR_B : ADDR_A;
            w_wdata = (w_sel == SEL_B) ? DATA_B : DATA_A;
            w_we    = in_range(w_waddr);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    assign w_ce[g] = w_we && (w_waddr == ADDR_W'(g));

    register #(
      .WIDTH (WIDTH)
    ) u_reg (
      .i_clk (CLK),
      .i_ce  (w_ce[g]),
      .i_d   (w_wdata),
      .o_q   (w_q[g])
    );
  end

  always_comb begin
    RD_DATA0 = '0;
    RD_DATA1 = '0;
    if (in_range(RD_ADDR0)) begin
      RD_DATA0 = w_q[RD_ADDR0];
    end
    if (in_range(RD_ADDR1)) begin
      RD_DATA1 = w_q[RD_ADDR1];
    end
`ifdef REGBANK_WRITE_BYPASS_EN
    if (w_we && (w_waddr == RD_ADDR0)) begin
      RD_DATA0 = w_wdata;
    end
    if (w_we && (w_waddr == RD_ADDR1)) begin
      RD_DATA1 = w_wdata;
    end
`endif
  end

  ack_exclusive: assert property (@(posedge CLK) disable iff (RST) !(ACK_A && ACK_B));
  ce_onehot: assert property (@(posedge CLK) $onehot0(w_ce));

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Randomized bench for regbank_write_arbiter against a transaction-level reference model.
module tb_regbank_write_arbiter;

  localparam int W  = 16;
  localparam int N  = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, req_b;
  logic [AW-1:0] addr_a, addr_b, rd_addr0, rd_addr1;
  logic [W-1:0]  data_a, data_b;
  logic          ack_a, ack_b, ready;
  logic [W-1:0]  rd_data0, rd_data1;

  always #5 clk = ~clk;

  regbank_write_arbiter #(
    .WIDTH  (W),
    .NREGS  (N),
    .ADDR_W (AW)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ_A    (req_a),
    .ADDR_A   (addr_a),
    .DATA_A   (data_a),
    .ACK_A    (ack_a),
    .REQ_B    (req_b),
    .ADDR_B   (addr_b),
    .DATA_B   (data_b),
    .ACK_B    (ack_b),
    .READY    (ready),
    .RD_ADDR0 (rd_addr0),
    .RD_ADDR1 (rd_addr1),
    .RD_DATA0 (rd_data0),
    .RD_DATA1 (rd_data1)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } txn_t;

  txn_t         qa[$];
  txn_t         qb[$];
  logic [W-1:0] m_regs [N];
  bit           m_known [N];
  int           m_walk  = 0;  // registers cleared since reset; N means arbitration is live
  bit           m_b_turn = 0;  // B wins the next tie
  bit           obs_ack_a, obs_ack_b;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_read(input int a, input bit we, input int wa,
                                  input logic [W-1:0] wd, output logic [W-1:0] v);
    if (a >= N) begin
      v = '0;
      return 1'b1;
    end
`ifdef REGBANK_WRITE_BYPASS_EN
    if (we && wa == a) begin
      v = wd;
      return 1'b1;
    end
`endif
    v = m_regs[a];
    return m_known[a];
  endfunction

  task automatic push_a(input int a, input int d);
    txn_t t;
    t.addr = AW'(a);
    t.data = W'(d);
    qa.push_back(t);
  endtask

  task automatic push_b(input int a, input int d);
    txn_t t;
    t.addr = AW'(a);
    t.data = W'(d);
    qb.push_back(t);
  endtask

  task automatic tick();
    bit           ga, gb, we, kn;
    int           wa;
    logic [W-1:0] wd, ev;
    req_a = (qa.size() > 0);
    req_b = (qb.size() > 0);
    if (req_a) begin
      addr_a = qa[0].addr;
      data_a = qa[0].data;
    end
    if (req_b) begin
      addr_b = qb[0].addr;
      data_b = qb[0].data;
    end
    ga = 0; gb = 0; we = 0; wa = 0; wd = '0;
    if (!rst) begin
      if (m_walk < N) begin
        we = 1;
        wa = m_walk;
      end else begin
        if (req_a && req_b) begin
          ga = !m_b_turn;
          gb = m_b_turn;
        end else begin
          ga = req_a;
          gb = req_b;
        end
        if (ga) begin
          wa = int'(addr_a);
          wd = data_a;
        end
        if (gb) begin
          wa = int'(addr_b);
          wd = data_b;
        end
        we = (ga || gb) && (wa < N);
      end
    end
    @(negedge clk);
    obs_ack_a = ack_a;
    obs_ack_b = ack_b;
    check_eq("ack_a", 32'(ack_a), 32'(ga));
    check_eq("ack_b", 32'(ack_b), 32'(gb));
    check_eq("ready", 32'(ready), 32'(!rst && m_walk == N));
    kn = exp_read(int'(rd_addr0), we, wa, wd, ev);
    if (kn) check_eq("rd_data0", 32'(rd_data0), 32'(ev));
    kn = exp_read(int'(rd_addr1), we, wa, wd, ev);
    if (kn) check_eq("rd_data1", 32'(rd_data1), 32'(ev));
    @(posedge clk);
    if (rst) begin
      m_walk   = 0;
      m_b_turn = 0;
    end else begin
      if (we) begin
        m_regs[wa]  = wd;
        m_known[wa] = 1'b1;
      end
      if (m_walk < N) m_walk++;
      if (ga) begin
        void'(qa.pop_front());
        m_b_turn = 1;
      end
      if (gb) begin
        void'(qb.pop_front());
        m_b_turn = 0;
      end
    end
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic walk_with_reads();
    for (int k = 0; k < N; k++) begin
      rd_addr0 = AW'(k);
      rd_addr1 = AW'((k + N - 1) % N);
      tick();
    end
  endtask

  initial begin
    int first;
    rst = 1'b1;
    req_a = 0; req_b = 0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    rd_addr0 = '0; rd_addr1 = '0;
    #1;
    repeat (2) tick();
    rst = 1'b0;
    walk_with_reads();

    // Fill with ones so the second clear walk is observable.
    for (int i = 0; i < N; i++) push_a(i, 16'hFFFF);
    drain(4 * N);
    for (int i = 0; i < N; i++) begin
      rd_addr0 = AW'(i);
      rd_addr1 = AW'(N - 1 - i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    walk_with_reads();

    // Contention right after reset: A wins first.
    push_a(1, 16'h1111);
    push_b(1, 16'h2222);
    rd_addr0 = 3'd1;
    drain(8);
    tick();

    // Single writer back-to-back.
    push_a(2, 16'h1234);
    push_a(3, 16'hABCD);
    push_a(2, 16'h0001);
    rd_addr0 = 3'd2;
    rd_addr1 = 3'd3;
    drain(8);
    tick();

    // A had the last grant, so B wins this tie.
    push_a(1, 16'h3333);
    push_b(1, 16'h4444);
    rd_addr0 = 3'd1;
    drain(8);
    tick();

    // Out-of-range addresses are acked but never stored.
    push_a(6, 16'hBEEF);
    push_b(7, 16'hCAFE);
    rd_addr0 = 3'd6;
    rd_addr1 = 3'd7;
    drain(8);
    tick();

    // Same-cycle read of the register being written.
    push_a(5, 16'h7777);
    rd_addr0 = 3'd5;
    rd_addr1 = 3'd5;
    drain(4);
    tick();

    // Request pending across the clear walk.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_b(0, 16'h0B0B);
    rd_addr0 = 3'd0;
    first = -1;
    for (int c = 0; c < N + 4; c++) begin
      tick();
      if (obs_ack_b && first < 0) first = c;
    end
    check_eq("clear_req_first_ack", 32'(first), 32'(N));

    // Reset lands on a cycle with a live grant.
    push_a(4, 16'h5555);
    rd_addr0 = 3'd4;
    rd_addr1 = 3'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    qa.delete();
    walk_with_reads();
    rd_addr0 = 3'd4;
    tick();

    for (int c = 0; c < 3000; c++) begin
      if (qa.size() < 2 && $urandom_range(0, 2) == 0) push_a($urandom_range(0, 7), $urandom);
      if (qb.size() < 2 && $urandom_range(0, 2) == 0) push_b($urandom_range(0, 7), $urandom);
      rd_addr0 = AW'($urandom_range(0, 7));
      rd_addr1 = AW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    drain(4 * N);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
